// File: rtl/md_unit.sv
// md_unit -- execute-stage multiply/divide unit with architectural HI/LO.
//
// A start pulse in IDLE computes the result of mult/multu/div/divu (and
// madd when enabled) into pending registers, then a down-counter models
// the multi-cycle latency. HI/LO take the pending values on the edge where
// the counter goes 1 -> 0. mthi/mtlo write HI/LO directly at the next edge.
// A start while busy is ignored. Reset is synchronous and active-high.
//
// Optional feature macro: MD_MADD_EN (md_op 7 = madd; otherwise op 7 is a no-op).
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu/madd (>= 1)
//   DIV_CYCLES   busy cycles for div/divu (>= 1)
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   E-stage md op this cycle
//   md_op   in   [2:0] 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 madd
//   rs_val  in   [31:0] rs operand
//   rt_val  in   [31:0] rt operand
//   busy    out  multi-cycle operation in flight (registered decode)
//   hi      out  [31:0] architectural HI
//   lo      out  [31:0] architectural LO

module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MADD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [31:0]    phi_q,   phi_d;
  logic [31:0]    plo_q,   plo_d;
  logic [31:0]    hi_q,    hi_d;
  logic [31:0]    lo_q,    lo_d;

  md_op_e op;
  assign op = md_op_e'(md_op);

  // Datapath for the result captured at the start edge.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic signed [31:0] dvsr_s;
  logic        [31:0] dvsr_u;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;

  assign prod_s   = 64'($signed(rs_val)) * 64'($signed(rt_val));
  assign prod_u   = 64'(rs_val) * 64'(rt_val);
  assign div_zero = (rt_val == '0);
  assign div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == '1);

  // Substituting a divisor of 1 keeps the dividers well defined: on the
  // overflow case it yields exactly LO = 0x80000000, HI = 0, and the
  // divide-by-zero result is discarded in favour of the current HI/LO.
  assign dvsr_s = (div_zero || div_ovf) ? 32'sd1 : $signed(rt_val);
  assign dvsr_u = div_zero ? 32'd1 : rt_val;
  assign quo_s  = $signed(rs_val) / dvsr_s;
  assign rem_s  = $signed(rs_val) % dvsr_s;
  assign quo_u  = rs_val / dvsr_u;
  assign rem_u  = rs_val % dvsr_u;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              {phi_d, plo_d} = prod_s;
              cnt_d          = CW'(MULT_CYCLES);
              state_d        = ST_RUN;
            end
            OP_MULTU: begin
              {phi_d, plo_d} = prod_u;
              cnt_d          = CW'(MULT_CYCLES);
              state_d        = ST_RUN;
            end
            OP_DIV: begin
              {phi_d, plo_d} = div_zero ? {hi_q, lo_q} : {rem_s, quo_s};
              cnt_d          = CW'(DIV_CYCLES);
              state_d        = ST_RUN;
            end
            OP_DIVU: begin
              {phi_d, plo_d} = div_zero ? {hi_q, lo_q} : {rem_u, quo_u};
              cnt_d          = CW'(DIV_CYCLES);
              state_d        = ST_RUN;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
`ifdef MD_MADD_EN
            OP_MADD: begin
              {phi_d, plo_d} = {hi_q, lo_q} + prod_s;
              cnt_d          = CW'(MULT_CYCLES);
              state_d        = ST_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
